alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Stage directly downstream of the 16-bit ALU. Consumes each ALU result word and 5-bit flag vector through a one-entry valid/ready pipeline register.
- Commits the result into a 16-entry register file and the flags into the processor status register (PSR).
- Provides two combinational read ports, with forwarding from the pending entry, back to the operand-fetch logic.

Parameters:
DATA_W, 16, datapath width
FLAG_W, 5, flag vector width ([4]=Z, [3]=C, [2]=F overflow, [1]=N, [0]=L)
ADDR_W, 4, register address width
REG_CNT, 16, number of registers (2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  ALU result present this cycle
in_ready  out  1  stage can accept this cycle
alu_c  in  DATA_W  ALU result
alu_flags  in  FLAG_W  ALU flags
alu_op  in  2  opcode that produced the result (00 ADDU, 01 ADD, 10 SUB, 11 CMP)
dest_addr  in  ADDR_W  destination register
stall  in  1  blocks commit of the pending entry
raddr_a  in  ADDR_W  read port A address
rdata_a  out  DATA_W  read port A data
raddr_b  in  ADDR_W  read port B address
rdata_b  out  DATA_W  read port B data
psr  out  FLAG_W  committed status register
pend_valid  out  1  an uncommitted entry is held
commit  out  1  pulse: entry committed this cycle

Behaviour:
- Reset is asynchronous, active-low: rst_n low immediately clears s1_valid, psr (5'b00000) and all registers (16'h0000).
  - While rst_n is low, outputs are in_ready=1, pend_valid=0 and commit=0.
  - A pending entry caught by reset is discarded and never committed.
- Pipeline register S1 holds {c, flags, op, dest}.
  - Handshake: data is accepted at a rising edge when in_valid && in_ready.
  - Inputs are don't-care when in_valid=0.
- commit = s1_valid && !stall, combinational. It acts at the same rising edge.
- in_ready = !s1_valid || commit. A capture and a commit in the same cycle are legal, giving sustained 1 result/cycle.
- Latency: the edge that captures an entry ends the accept cycle; the earliest commit is at the next edge. The committed register value and PSR are visible on the outputs the cycle after the commit edge.
- stall=1 with s1_valid=1 holds S1 unchanged and drives in_ready=0. stall is ignored when S1 is empty.
- Commit actions by op:
  - ADDU: rf[dest]<=c; psr[4]<=Z, psr[3]<=C; psr[2:0] unchanged.
  - ADD/SUB: rf[dest]<=c; psr[4]<=Z, psr[2]<=F; psr[3], psr[1:0] unchanged.
  - CMP: no register write; psr[1:0]<=flags[1:0]; psr[4:2] unchanged.
- Read ports are combinational, with priority:
  1. If s1_valid && op!=CMP && dest==raddr, return S1.c (forward the pending entry, committed or not).
  2. Otherwise return rf[raddr].
- All registers, including r0, are writable. There is no hard-wired zero.
- pend_valid = s1_valid.
- psr reflects committed state only. PSR is not forwarded.
- Every entry commits exactly once. No entry is dropped, duplicated or reordered.

Decomposition:
- Package alu_pkg holds:
  - opcode constants ADDU/ADD/SUB/CMP;
  - flag bit indices FLG_Z=4, FLG_C=3, FLG_F=2, FLG_N=1, FLG_L=0;
  - per-opcode PSR update masks (ADDU 5'b11000, ADD/SUB 5'b10100, CMP 5'b00011);
  - DATA_W/FLAG_W defaults.
- One sub-module, reg_file_16x16:
  - one synchronous write port, two asynchronous read ports;
  - asynchronous active-low clear.
- Forwarding muxes, S1 and PSR live in the top level.

Test Plan:
1. Reset, then raddr_a=0..15 -> rdata_a=16'h0000 for every address, psr=5'b00000, in_ready=1. Assert rst_n low mid-stall with a pending entry -> pend_valid drops immediately; the target register stays 0 after release.
2. Send ADD c=16'h1234, flags=5'b00100, dest=3 with stall=0 -> commit pulses the next cycle; rf[3]=16'h1234 and psr=5'b00100 one cycle later. rdata_a(raddr=3) returns 16'h1234 while pending via forwarding.
3. Send ADDU flags=5'b11000, then CMP flags=5'b00011, c=16'h0000, dest=5 -> psr=5'b11000, then 5'b11011; rf[5] untouched; CMP is not forwarded on raddr=5.
4. Stall for 3 cycles holding SUB dest=7 c=16'hFFFF while in_valid=1 with a new entry -> in_ready=0 for 3 cycles; neither entry is lost; rf[7]=16'hFFFF; the second entry commits the cycle after stall drops.
5. Back-to-back stream of 8 ADDs to dest=2 with c=1..8 and stall=0 -> one accept per cycle; rf[2]=8 at the end; each intermediate value is visible via forwarding in order.
6. Mask check: SUB with flags=5'b11111 over psr=5'b00000 -> psr=5'b10100, with C/N/L unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and PSR-mask definitions for the ALU writeback stage.
package alu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FLAG_W = 5;
    localparam int DEF_ADDR_W = 4;

    localparam int FLG_Z = 4;
    localparam int FLG_C = 3;
    localparam int FLG_F = 2;
    localparam int FLG_N = 1;
    localparam int FLG_L = 0;

    typedef enum logic [1:0] {
        ADDU = 2'b00,
        ADD  = 2'b01,
        SUB  = 2'b10,
        CMP  = 2'b11
    } alu_op_e;

    // Which PSR bits an opcode is allowed to overwrite on commit.
    function automatic logic [DEF_FLAG_W-1:0] psr_mask(input alu_op_e op);
        logic [DEF_FLAG_W-1:0] m;
        m = '0;
        case (op)
            ADDU: begin
                m[FLG_Z] = 1'b1;
                m[FLG_C] = 1'b1;
            end
            ADD, SUB: begin
                m[FLG_Z] = 1'b1;
                m[FLG_F] = 1'b1;
            end
            CMP: begin
                m[FLG_N] = 1'b1;
                m[FLG_L] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/reg_file_16x16.sv
// Register file: one synchronous write port, two asynchronous read ports, async clear.
module reg_file_16x16 #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int REG_CNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [REG_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry valid/ready holding register, register file commit,
// PSR update and forwarding read ports.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FLAG_W  = DEF_FLAG_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_CNT = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [1:0]        alu_op,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              stall,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [FLAG_W-1:0] psr,
    output logic              pend_valid,
    output logic              commit
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_c;
    logic [FLAG_W-1:0] r_s1_flags;
    alu_op_e           r_s1_op;
    logic [ADDR_W-1:0] r_s1_dest;
    logic [FLAG_W-1:0] r_psr;

    logic              w_commit;
    logic              w_ready;
    logic              w_rf_we;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [FLAG_W-1:0] w_mask;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;

    assign w_commit = r_s1_valid && !stall;
    assign w_ready  = !r_s1_valid || w_commit;
    assign w_rf_we  = w_commit && (r_s1_op != CMP);
    assign w_mask   = psr_mask(r_s1_op);

    // A commit frees the slot in the same cycle, so capture and commit may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_flags <= '0;
            r_s1_op    <= ADDU;
            r_s1_dest  <= '0;
        end else if (w_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_c     <= alu_c;
                r_s1_flags <= alu_flags;
                r_s1_op    <= alu_op_e'(alu_op);
                r_s1_dest  <= dest_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psr <= '0;
        end else if (w_commit) begin
            r_psr <= (r_psr & ~w_mask) | (r_s1_flags & w_mask);
        end
    end

    reg_file_16x16 #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .REG_CNT (REG_CNT)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (r_s1_dest),
        .i_wdata   (r_s1_c),
        .i_raddr_a (raddr_a),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (raddr_b),
        .o_rdata_b (w_rf_b)
    );

    // The pending entry is the newest value of its destination; CMP never writes one.
    assign w_fwd_a = r_s1_valid && (r_s1_op != CMP) && (r_s1_dest == raddr_a);
    assign w_fwd_b = r_s1_valid && (r_s1_op != CMP) && (r_s1_dest == raddr_b);

    assign rdata_a    = w_fwd_a ? r_s1_c : w_rf_a;
    assign rdata_b    = w_fwd_b ? r_s1_c : w_rf_b;
    assign psr        = r_psr;
    assign pend_valid = r_s1_valid;
    assign commit     = w_commit;
    assign in_ready   = w_ready;

endmodule
